// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional frame encoder.
//   state_e     : frame FSM states (data bits, zero tail)
//   G_7 / G_5   : the classic (2,1,3) generator polynomials, used as defaults
//   cnt_width() : bit width for a counter that spans 0..n-1 (at least 1)
//   parity()    : XOR-reduction of a tap-masked window
package conv_pkg;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_TAIL = 1'b1
  } state_e;

  localparam logic [2:0] G_7 = 3'b111;
  localparam logic [2:0] G_5 = 3'b101;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/conv_enc_frame_sym_serializer.sv
// Output holding stage for the encoder.
// Holds one encoded symbol and presents it either as a whole (SERIAL=0) or
// one bit per beat, MSB first (SERIAL=1).
//   clk_sig, reset_sig : clock, asynchronous active-low reset
//   load, sym_in, last_in : new symbol from the encoder (only when can_load)
//   out_ready          : downstream accepts the current beat
//   out_valid, out_data, out_last : output beat
//   can_load           : stage is empty or its final beat drains this cycle
module sym_serializer
  import conv_pkg::*;
#(
  parameter int N      = 2,
  parameter int SERIAL = 0,
  localparam int OW    = (SERIAL != 0) ? 1 : N
) (
  input  logic          clk_sig,
  input  logic          reset_sig,
  input  logic          load,
  input  logic [N-1:0]  sym_in,
  input  logic          last_in,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic          can_load
);

  localparam int BW = cnt_width(N);
  localparam logic [BW-1:0] BEAT_LAST = BW'(N - 1);

  logic [N-1:0]  sym_q, sym_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          final_beat;

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      sym_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      sym_q   <= sym_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    // In parallel mode every beat is the final beat of its symbol.
    final_beat = (SERIAL == 0) || (beat_q == BEAT_LAST);
    can_load   = !valid_q || (out_ready && final_beat);
    sym_d      = sym_q;
    beat_d     = beat_q;
    valid_d    = valid_q;
    last_d     = last_q;
    if (load) begin
      // Loading may coincide with the final beat draining: no bubble.
      sym_d   = sym_in;
      last_d  = last_in;
      valid_d = 1'b1;
      beat_d  = '0;
    end else if (valid_q && out_ready) begin
      if (final_beat) begin
        valid_d = 1'b0;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end
  end

  assign out_valid = valid_q;
  assign out_last  = valid_q && last_q && final_beat;

  generate
    if (SERIAL != 0) begin : g_serial
      assign out_data = sym_q[BEAT_LAST - beat_q];
    end else begin : g_parallel
      assign out_data = sym_q;
    end
  endgenerate

endmodule

// File: rtl/conv_enc_frame.sv
// Rate-1/N convolutional encoder with framing and optional zero-tail
// termination, feeding a symbol holding / serialising stage.
//   clk_sig, reset_sig : clock, asynchronous active-low reset
//   in_valid, in_bit, in_ready : source bit handshake
//   out_valid, out_data, out_last, out_ready : encoded output handshake
//   out_data is N bits wide (SERIAL=0) or 1 bit wide (SERIAL=1)
module conv_enc_frame
  import conv_pkg::*;
#(
  parameter int K                = 3,
  parameter int N                = 2,
  parameter logic [N*K-1:0] GEN  = {G_5, G_7},
  parameter int FRAME_LEN        = 2048,
  parameter int TERMINATE        = 1,
  parameter int SERIAL           = 0,
  localparam int OW              = (SERIAL != 0) ? 1 : N
) (
  input  logic          clk_sig,
  input  logic          reset_sig,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic          in_ready,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready
);

  localparam int FW = cnt_width(FRAME_LEN);
  localparam int TW = cnt_width(K - 1);
  localparam logic [FW-1:0] BIT_LAST  = FW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);

  state_e        state_q, state_d;
  logic [K-2:0]  sr_q, sr_d;
  logic [FW-1:0] bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tail_cnt_q, tail_cnt_d;

  logic          can_load;
  logic          accept;
  logic          load;
  logic          enc_in;
  logic          sym_last;
  logic [K-1:0]  win;
  logic [N-1:0]  sym;

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      state_q    <= ST_DATA;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      tail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      tail_cnt_q <= tail_cnt_d;
    end
  end

  // Control outputs: the tail phase feeds zeros and blocks the source.
  always_comb begin
    in_ready = (state_q == ST_DATA) && can_load;
    accept   = in_ready && in_valid;
    enc_in   = (state_q == ST_DATA) ? in_bit : 1'b0;
    load     = accept || ((state_q == ST_TAIL) && can_load);
    sym_last = 1'b0;
    if (state_q == ST_DATA) begin
      sym_last = (TERMINATE == 0) && (bit_cnt_q == BIT_LAST);
    end else begin
      sym_last = (tail_cnt_q == TAIL_LAST);
    end
  end

  // Window bit i is the input from i steps ago; sr[0] holds the newest.
  always_comb begin
    win = {sr_q, enc_in};
    sym = '0;
    for (int j = 0; j < N; j++) begin
      sym[j] = parity(32'(win & GEN[j*K +: K]));
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    tail_cnt_d = tail_cnt_q;
    if (load) begin
      sr_d = win[K-2:0];
    end
    case (state_q)
      ST_DATA: begin
        if (accept) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (TERMINATE != 0) begin
              state_d    = ST_TAIL;
              tail_cnt_d = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + FW'(1);
          end
        end
      end
      ST_TAIL: begin
        // After K-1 zero inputs the shift register is empty again.
        if (can_load) begin
          if (tail_cnt_q == TAIL_LAST) begin
            tail_cnt_d = '0;
            state_d    = ST_DATA;
          end else begin
            tail_cnt_d = tail_cnt_q + TW'(1);
          end
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  sym_serializer #(
    .N      (N),
    .SERIAL (SERIAL)
  ) u_ser (
    .clk_sig   (clk_sig),
    .reset_sig (reset_sig),
    .load      (load),
    .sym_in    (sym),
    .last_in   (sym_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .can_load  (can_load)
  );

endmodule

// File: tb/tb_conv_enc_frame.sv
// Bench for conv_enc_frame: four parameterisations side by side.
//   inst0: defaults, FRAME_LEN=4, terminated, parallel
//   inst1: FRAME_LEN=3, continuous, parallel
//   inst2: FRAME_LEN=4, terminated, serial
//   inst3: K=4, N=3, FRAME_LEN=1000, terminated, parallel
module tb_conv_enc_frame;

  logic clk_sig = 1'b0;
  logic reset_sig;
  always #5 clk_sig = ~clk_sig;

  logic [3:0] in_valid, in_bit, out_ready;
  logic [3:0] in_ready, out_valid, out_last;
  logic [1:0] od0, od1;
  logic [0:0] od2;
  logic [2:0] od3;
  logic [7:0] odata [4];

  assign odata[0] = {6'd0, od0};
  assign odata[1] = {6'd0, od1};
  assign odata[2] = {7'd0, od2};
  assign odata[3] = {5'd0, od3};

  conv_enc_frame #(.FRAME_LEN(4)) u_a (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .in_valid(in_valid[0]), .in_bit(in_bit[0]),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_data(od0), .out_last(out_last[0]),
    .out_ready(out_ready[0]));

  conv_enc_frame #(.FRAME_LEN(3), .TERMINATE(0)) u_b (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .in_valid(in_valid[1]), .in_bit(in_bit[1]),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_data(od1), .out_last(out_last[1]),
    .out_ready(out_ready[1]));

  conv_enc_frame #(.FRAME_LEN(4), .SERIAL(1)) u_c (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .in_valid(in_valid[2]), .in_bit(in_bit[2]),
    .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_data(od2), .out_last(out_last[2]),
    .out_ready(out_ready[2]));

  conv_enc_frame #(.K(4), .N(3), .GEN({4'b1111, 4'b1101, 4'b1011}), .FRAME_LEN(1000)) u_d (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .in_valid(in_valid[3]), .in_bit(in_bit[3]),
    .in_ready(in_ready[3]), .out_valid(out_valid[3]), .out_data(od3), .out_last(out_last[3]),
    .out_ready(out_ready[3]));

  // Reference parameters for the model, one entry per instance.
  int          pk   [4] = '{3, 3, 3, 4};
  int          pn   [4] = '{2, 2, 2, 3};
  int          pfl  [4] = '{4, 3, 4, 1000};
  int          pterm[4] = '{1, 0, 1, 1};
  int          pser [4] = '{0, 0, 1, 0};
  logic [31:0] pgen [4] = '{32'b101_111, 32'b101_111, 32'b101_111, 32'b1111_1101_1011};
  int          tgt  [4] = '{100, 30, 20, 2};

  int n_cmp, n_fail;

  // Model state: input history (bit t = input t steps ago) and expected beats.
  logic [31:0] hist [4];
  int          bits_in [4];
  int          frames_in [4];
  int          frames_out [4];
  logic [3:0]  stall_prev;
  logic [8:0]  held [4];
  logic [8:0]  q0[$], q1[$], q2[$], q3[$];

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got 0x%0h, required 0x%0h", name, i, $time, act, exp);
    end
  endtask

  task automatic q_push(input int i, input logic [8:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  function automatic int q_size(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic q_pop(input int i, output logic [8:0] v);
    case (i)
      0: v = q0.pop_front();
      1: v = q1.pop_front();
      2: v = q2.pop_front();
      default: v = q3.pop_front();
    endcase
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    for (int i = 0; i < 4; i++) begin
      hist[i] = '0; bits_in[i] = 0; frames_in[i] = 0; frames_out[i] = 0; held[i] = '0;
    end
    stall_prev = '0;
  endtask

  // Encode one input bit: output j = XOR over taps t of g_j[t] * x[n-t].
  task automatic model_bit(input int i, input logic b, input logic last);
    logic [7:0] sym;
    hist[i] = {hist[i][30:0], b};
    sym = '0;
    for (int j = 0; j < pn[i]; j++)
      for (int t = 0; t < pk[i]; t++)
        sym[j] = sym[j] ^ (pgen[i][j*pk[i] + t] & hist[i][t]);
    if (pser[i] != 0) begin
      for (int j = pn[i] - 1; j >= 0; j--) q_push(i, {last && (j == 0), 7'd0, sym[j]});
    end else begin
      q_push(i, {last, sym});
    end
  endtask

  task automatic model_accept(input int i, input logic b);
    bits_in[i]++;
    if (bits_in[i] == pfl[i]) begin
      bits_in[i] = 0;
      frames_in[i]++;
      if (pterm[i] != 0) begin
        model_bit(i, b, 1'b0);
        for (int t = 0; t < pk[i] - 1; t++) model_bit(i, 1'b0, t == pk[i] - 2);
      end else begin
        model_bit(i, b, 1'b1);
      end
    end else begin
      model_bit(i, b, 1'b0);
    end
  endtask

  // Stream monitor: stall stability, beat-by-beat comparison, model feed.
  initial begin
    logic [8:0] cur, expv;
    forever begin
      @(negedge clk_sig);
      if (!reset_sig) begin
        model_reset();
      end else begin
        for (int i = 0; i < 4; i++) begin
          cur = {out_last[i], odata[i]};
          if (stall_prev[i]) chk("stall_hold", i, 32'({out_valid[i], cur}), 32'({1'b1, held[i]}));
          if (out_valid[i] && out_ready[i]) begin
            if (q_size(i) == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL beat_unexpected inst%0d @%0t: got 0x%0h, required no beat", i, $time, cur);
            end else begin
              q_pop(i, expv);
              chk("stream", i, 32'(cur), 32'(expv));
            end
            if (out_last[i]) frames_out[i]++;
          end
          stall_prev[i] = out_valid[i] && !out_ready[i];
          held[i] = cur;
          if (in_valid[i] && in_ready[i]) model_accept(i, in_bit[i]);
        end
      end
    end
  end

  typedef struct {
    int         inst;
    logic       rst;
    logic       iv, ib, ordy;
    logic       e_rdy, e_vld;
    logic [7:0] e_dat;
    logic       e_last;
  } vec_t;

  function automatic vec_t mk(int inst, logic rst, logic iv, logic ib, logic ordy,
                              logic e_rdy, logic e_vld, logic [7:0] e_dat, logic e_last);
    vec_t v;
    v.inst = inst; v.rst = rst; v.iv = iv; v.ib = ib; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dat = e_dat; v.e_last = e_last;
    return v;
  endfunction

  task automatic idle_all();
    in_valid = '0; in_bit = '0; out_ready = '1;
  endtask

  task automatic do_reset();
    @(posedge clk_sig); #1;
    idle_all();
    reset_sig = 1'b0;
    @(negedge clk_sig);
    @(posedge clk_sig); #1;
    reset_sig = 1'b1;
  endtask

  task automatic apply_row(input vec_t v);
    if (v.rst) do_reset();
    @(posedge clk_sig); #1;
    idle_all();
    in_valid[v.inst] = v.iv; in_bit[v.inst] = v.ib; out_ready[v.inst] = v.ordy;
    @(negedge clk_sig);
    chk("in_ready", v.inst, 32'(in_ready[v.inst]), 32'(v.e_rdy));
    chk("out_valid", v.inst, 32'(out_valid[v.inst]), 32'(v.e_vld));
    if (v.e_vld) chk("out_data", v.inst, 32'(odata[v.inst]), 32'(v.e_dat));
    chk("out_last", v.inst, 32'(out_last[v.inst]), 32'(v.e_last));
  endtask

  vec_t tbl[$];
  int   cyc;
  bit   done;

  initial begin
    n_cmp = 0; n_fail = 0;
    reset_sig = 1'b0;
    idle_all();
    model_reset();
    repeat (3) @(posedge clk_sig);
    @(negedge clk_sig);
    for (int i = 0; i < 4; i++) begin
      chk("rst_out_valid", i, 32'(out_valid[i]), 32'd0);
      chk("rst_out_last", i, 32'(out_last[i]), 32'd0);
      chk("rst_out_data", i, 32'(odata[i]), 32'd0);
    end
    @(posedge clk_sig); #1;
    reset_sig = 1'b1;
    @(negedge clk_sig);
    for (int i = 0; i < 4; i++) chk("rst_in_ready", i, 32'(in_ready[i]), 32'd1);

    // inst0: frame 1,0,1,1 then two tail symbols, then a new frame starts.
    tbl.push_back(mk(0, 1, 1, 1, 1,  1, 0, 8'b00, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1,  1, 1, 8'b11, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1,  1, 1, 8'b01, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1,  1, 1, 8'b00, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1,  0, 1, 8'b10, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1,  0, 1, 8'b10, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1,  1, 1, 8'b11, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1,  1, 1, 8'b11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,  1, 0, 8'b00, 0));
    // inst0: stall holds the symbol and blocks input; drain and load together.
    tbl.push_back(mk(0, 1, 1, 1, 1,  1, 0, 8'b00, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  0, 1, 8'b11, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1,  1, 1, 8'b11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,  1, 1, 8'b01, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,  1, 0, 8'b00, 0));
    // inst1: continuous frames 1,0,0 | 0,1,1 | 0,0,0 with history carried.
    tbl.push_back(mk(1, 1, 1, 1, 1,  1, 0, 8'b00, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  1, 1, 8'b11, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  1, 1, 8'b01, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  1, 1, 8'b11, 1));
    tbl.push_back(mk(1, 0, 1, 1, 1,  1, 1, 8'b00, 0));
    tbl.push_back(mk(1, 0, 1, 1, 1,  1, 1, 8'b11, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  1, 1, 8'b10, 1));
    tbl.push_back(mk(1, 0, 1, 0, 1,  1, 1, 8'b10, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  1, 1, 8'b11, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1,  1, 1, 8'b00, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1,  1, 0, 8'b00, 0));
    // inst2 serial: bit 1 -> beats 1,1 (with a stall); bit 0 -> beats 0,1.
    tbl.push_back(mk(2, 1, 1, 1, 1,  1, 0, 8'b0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0,  0, 1, 8'b1, 0));
    tbl.push_back(mk(2, 0, 0, 0, 1,  0, 1, 8'b1, 0));
    tbl.push_back(mk(2, 0, 1, 0, 1,  1, 1, 8'b1, 0));
    tbl.push_back(mk(2, 0, 0, 0, 1,  0, 1, 8'b0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 1,  1, 1, 8'b1, 0));
    tbl.push_back(mk(2, 0, 0, 0, 1,  1, 0, 8'b0, 0));
    for (int r = 0; r < tbl.size(); r++) apply_row(tbl[r]);

    // Reset in the middle of a frame while a symbol is held.
    apply_row(mk(0, 1, 1, 1, 1,  1, 0, 8'b00, 0));
    apply_row(mk(0, 0, 1, 1, 1,  1, 1, 8'b11, 0));
    @(posedge clk_sig); #1;
    idle_all();
    reset_sig = 1'b0;
    #1;
    chk("rst_mid_valid", 0, 32'(out_valid[0]), 32'd0);
    @(negedge clk_sig);
    chk("rst_mid_valid_next", 0, 32'(out_valid[0]), 32'd0);
    @(posedge clk_sig); #1;
    reset_sig = 1'b1;
    // Fresh frame: first symbol proves sr=0, tail after 4 bits proves bit_cnt=0.
    apply_row(mk(0, 0, 1, 1, 1,  1, 0, 8'b00, 0));
    apply_row(mk(0, 0, 1, 0, 1,  1, 1, 8'b11, 0));
    apply_row(mk(0, 0, 1, 1, 1,  1, 1, 8'b01, 0));
    apply_row(mk(0, 0, 1, 1, 1,  1, 1, 8'b00, 0));
    apply_row(mk(0, 0, 0, 0, 1,  0, 1, 8'b10, 0));

    // Random traffic with backpressure on every instance.
    do_reset();
    done = 1'b0;
    for (cyc = 0; cyc < 60000 && !done; cyc++) begin
      @(posedge clk_sig); #1;
      for (int i = 0; i < 4; i++) begin
        in_valid[i]  = (frames_in[i] < tgt[i]) && ($urandom_range(0, 3) != 0);
        in_bit[i]    = 1'($urandom_range(0, 1));
        out_ready[i] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk_sig);
      done = 1'b1;
      for (int i = 0; i < 4; i++)
        if (frames_out[i] < tgt[i] || q_size(i) != 0) done = 1'b0;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL random_timeout: got incomplete traffic after %0d cycles, required all frames drained", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      chk("frames_out", i, 32'(frames_out[i]), 32'(tgt[i]));
      chk("queue_drained", i, 32'(q_size(i)), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
